sd_sector_server: RTL and testbench
===================================

SD_SECTOR_SERVER -- requirements
Module: sd_sector_server

Interface
REQ-001 SHALL have parameter LBA_BITS, default 6, giving the number of valid sector-address bits (64 sectors of 512 bytes).
REQ-002 SHALL have parameter ACK_DELAY, default 4, giving the number of clk_sys cycles from request acceptance to sd_ack rise (range 1..255).
REQ-003 SHALL have port clk_sys, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sd_lba, input, 32 bits: sector number of the request.
REQ-006 SHALL have port sd_rd, input, 1 bit: level request to deliver a sector into the core's buffer.
REQ-007 SHALL have port sd_wr, input, 1 bit: level request to take a sector from the core's buffer.
REQ-008 SHALL have port sd_ack, output, 1 bit: high for the whole sector transfer.
REQ-009 SHALL have port sd_buff_addr, output, 8 bits: word index within the sector (0..255).
REQ-010 SHALL have port sd_buff_dout, output, 16 bits: word written into the core's buffer.
REQ-011 SHALL have port sd_buff_wr, output, 1 bit: one-cycle write strobe for sd_buff_dout.
REQ-012 SHALL have port sd_buff_din, input, 16 bits: core buffer read data, valid 2 cycles after sd_buff_addr changes.
REQ-013 SHALL have port mem_addr, output, LBA_BITS+8 bits: backing word address, equal to {lba[LBA_BITS-1:0], word index}.
REQ-014 SHALL have port mem_rd, output, 1 bit: backing read request, held until mem_ready.
REQ-015 SHALL have port mem_we, output, 1 bit: backing write request, held until mem_ready.
REQ-016 SHALL have port mem_wdata, output, 16 bits: backing write data.
REQ-017 SHALL have port mem_rdata, input, 16 bits: backing read data, valid in the mem_ready cycle.
REQ-018 SHALL have port mem_ready, input, 1 bit: one-cycle completion of mem_rd or mem_we.
REQ-019 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-020 SHALL have port err, output, 1 bit: sticky out-of-range flag.

Function
REQ-021 SHALL implement the states IDLE, DELAY, RD_MEM, RD_PUT, WR_ADDR, WR_WAIT, WR_MEM, DONE and GAP.
REQ-022 SHALL, in IDLE, accept the request when sd_rd or sd_wr is high, latching sd_lba and the operation; sd_rd SHALL win when both are high.
REQ-023 SHALL, in DELAY, count ACK_DELAY cycles, raise sd_ack, set the word index to 0, and go to RD_MEM (read) or WR_ADDR (write).
REQ-024 SHALL, for reads, assert mem_rd in RD_MEM until mem_ready, capture mem_rdata, then in RD_PUT drive sd_buff_addr=index, sd_buff_dout=data and sd_buff_wr=1 for exactly one cycle.
REQ-025 SHALL, for writes, drive sd_buff_addr=index in WR_ADDR, wait in WR_WAIT, and sample sd_buff_din on the second rising edge after the address is presented into mem_wdata.
REQ-026 SHALL, for writes, assert mem_we in WR_MEM until mem_ready.
REQ-027 SHALL increment the 8-bit index after each word; word 255 SHALL go to DONE instead of wrapping.
REQ-028 SHALL drop sd_ack in DONE, then spend one cycle in GAP before IDLE, so a released request is not re-accepted.
REQ-029 SHALL treat a request as out of range when sd_lba[31:LBA_BITS] != 0.
REQ-030 SHALL, for an out-of-range request, still run the full handshake with no mem_rd/mem_we: reads deliver 256 words of 0x0000, writes discard data, and err is set.
REQ-031 SHALL ignore sd_rd/sd_wr changes while busy; requests are sampled only in IDLE.
REQ-032 SHALL keep mem_rd and mem_we mutually exclusive and never assert either outside RD_MEM/WR_MEM.
REQ-033 SHALL hold sd_buff_addr at the last driven value when not transferring.
REQ-034 SHALL bound the transfer of one sector to 256 x (mem latency + 2 or 3) + ACK_DELAY + 2 cycles.

Reset
REQ-035 SHALL, on reset_n low, asynchronously force state=IDLE and index=0, and drive every output (sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr, mem_rd, mem_we, mem_wdata, busy, err) to 0.
REQ-036 SHALL abort any transfer on reset mid-sector with no further strobes, and SHALL accept no request until the first rising edge after reset_n goes high.

Verification
REQ-037 SHALL be verified for a read: backing word k = 0x1000+k, sd_rd with lba=3 -> sd_ack rises 4 cycles after acceptance, 256 sd_buff_wr strobes with addr k and dout 0x1000+k, mem_addr = 0x300+k.
REQ-038 SHALL be verified for a write: buffer word k = ~k, sd_wr with lba=5 -> mem_we at 0x500+k with data ~k, sd_ack low after word 255, then GAP then IDLE.
REQ-039 SHALL be verified for priority: sd_rd and sd_wr high together with lba=0 -> read performed, no mem_we.
REQ-040 SHALL be verified out of range: sd_rd with lba=64 -> 256 strobes of 0x0000, no mem_rd, err=1 and held.
REQ-041 SHALL be verified for reset mid-operation: reset_n low at word 100 -> outputs 0 immediately; a new sd_rd with lba=1 after release completes all 256 words.
REQ-042 SHALL be verified for back-to-back requests: the requester re-raises sd_rd on the sd_ack fall with lba+1 for 16 sectors -> 16 complete transfers, no sector skipped or repeated.

Source files
------------

// File: rtl/sd_sector_server.sv
// sd_sector_server: serves 512-byte sectors between a core's sector buffer
// (sd_* handshake, 16-bit words, 256 per sector) and a word-addressed backing
// memory (mem_* request/ready handshake).
//
// Ports
//   clk_sys, reset_n         clock, asynchronous active-low reset
//   sd_lba, sd_rd, sd_wr     request from the core (levels, sampled in IDLE)
//   sd_ack                   high for the whole sector transfer
//   sd_buff_addr/dout/wr     word index, data and write strobe into the core buffer
//   sd_buff_din              core buffer read data (registered by the core)
//   mem_addr/rd/we/wdata     backing memory request, held until mem_ready
//   mem_rdata, mem_ready     backing memory response
//   busy, err                FSM not idle; sticky out-of-range flag
//
// state   | meaning
// IDLE    | waiting for sd_rd / sd_wr
// DELAY   | counting down to sd_ack rise
// RD_MEM  | backing read outstanding
// RD_PUT  | one-cycle write strobe into the core buffer
// WR_ADDR | buffer address presented
// WR_WAIT | waiting for buffer read data
// WR_MEM  | backing write outstanding
// DONE    | sd_ack low, transfer finished
// GAP     | one dead cycle so a released request is not re-accepted
module sd_sector_server #(
    parameter int LBA_BITS  = 6,
    parameter int ACK_DELAY = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [7:0]            sd_buff_addr,
    output logic [15:0]           sd_buff_dout,
    output logic                  sd_buff_wr,
    input  logic [15:0]           sd_buff_din,
    output logic [LBA_BITS+7:0]   mem_addr,
    output logic                  mem_rd,
    output logic                  mem_we,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  err
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_DELAY   = 4'd1;
    localparam logic [3:0] S_RD_MEM  = 4'd2;
    localparam logic [3:0] S_RD_PUT  = 4'd3;
    localparam logic [3:0] S_WR_ADDR = 4'd4;
    localparam logic [3:0] S_WR_WAIT = 4'd5;
    localparam logic [3:0] S_WR_MEM  = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_GAP     = 4'd8;

    // Down-counter terminal count at 0: ACK_DELAY edges from acceptance to sd_ack.
    localparam logic [7:0] DLY_INIT = 8'(ACK_DELAY - 1);

    logic [3:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          idx_q, idx_d;
    logic [LBA_BITS-1:0] lba_q, lba_d;
    logic                is_wr_q, is_wr_d;
    logic                oor_q, oor_d;
    logic                ack_q, ack_d;
    logic [7:0]          baddr_q, baddr_d;
    logic [15:0]         bdout_q, bdout_d;
    logic                bwr_q, bwr_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic                req_oor;

    assign req_oor = (sd_lba >> LBA_BITS) != 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lba_d   = lba_q;
        is_wr_d = is_wr_q;
        oor_d   = oor_q;
        ack_d   = ack_q;
        baddr_d = baddr_q;
        bdout_d = bdout_q;
        bwr_d   = 1'b0;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_d   = sd_lba[LBA_BITS-1:0];
                    is_wr_d = !sd_rd;
                    oor_d   = req_oor;
                    err_d   = err_q | req_oor;
                    cnt_d   = DLY_INIT;
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (cnt_q == 8'd0) begin
                    ack_d = 1'b1;
                    idx_d = 8'd0;
                    if (is_wr_q) begin
                        baddr_d = 8'd0;
                        state_d = S_WR_ADDR;
                    end else begin
                        state_d = S_RD_MEM;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_RD_MEM: begin
                // Out-of-range sectors read as zeros without touching memory.
                if (oor_q || mem_ready) begin
                    bdout_d = oor_q ? 16'h0000 : mem_rdata;
                    baddr_d = idx_q;
                    bwr_d   = 1'b1;
                    state_d = S_RD_PUT;
                end
            end
            S_RD_PUT: begin
                if (idx_q == 8'hFF) begin
                    ack_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_RD_MEM;
                end
            end
            S_WR_ADDR: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                // Second edge after sd_buff_addr changed: buffer data has settled.
                if (!oor_q) wdata_d = sd_buff_din;
                state_d = S_WR_MEM;
            end
            S_WR_MEM: begin
                if (oor_q || mem_ready) begin
                    if (idx_q == 8'hFF) begin
                        ack_d   = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        baddr_d = idx_q + 8'd1;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            lba_q   <= '0;
            is_wr_q <= 1'b0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            baddr_q <= '0;
            bdout_q <= '0;
            bwr_q   <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lba_q   <= lba_d;
            is_wr_q <= is_wr_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            baddr_q <= baddr_d;
            bdout_q <= bdout_d;
            bwr_q   <= bwr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign sd_ack       = ack_q;
    assign sd_buff_addr = baddr_q;
    assign sd_buff_dout = bdout_q;
    assign sd_buff_wr   = bwr_q;
    assign mem_addr     = {lba_q, idx_q};
    assign mem_rd       = (state_q == S_RD_MEM) && !oor_q;
    assign mem_we       = (state_q == S_WR_MEM) && !oor_q;
    assign mem_wdata    = wdata_q;
    assign busy         = (state_q != S_IDLE);
    assign err          = err_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// Testbench for sd_sector_server: backing memory and core buffer models with
// a scoreboard of expected buffer strobes, memory reads and memory writes.
module tb_sd_sector_server;

    localparam int LBA_BITS  = 6;
    localparam int ACK_DELAY = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [31:0] sd_lba;
    logic        sd_rd, sd_wr;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din;
    logic [13:0] mem_addr;
    logic        mem_rd, mem_we;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        busy, err;

    sd_sector_server #(.LBA_BITS(LBA_BITS), .ACK_DELAY(ACK_DELAY)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] bmem     [0:16383];
    logic [15:0] core_buf [0:255];
    logic [15:0] buf_pipe;
    int          lat_cnt;
    logic        ack_prev;
    int          ack_rises;

    logic [23:0] rd_q[$];   // {buff_addr, buff_dout}
    logic [13:0] mr_q[$];   // backing read address
    logic [29:0] mw_q[$];   // {mem_addr, mem_wdata}

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Memory responder, core buffer pipeline and scoreboard checks, all away
    // from the active clock edge.
    always @(negedge clk_sys) begin
        sd_buff_din = buf_pipe;
        buf_pipe    = core_buf[sd_buff_addr];

        if (mem_rd || mem_we)
            check_eq("mem_excl", {63'd0, mem_rd & mem_we}, 64'd0);

        if (!reset_n) begin
            mem_ready = 1'b0;
            lat_cnt   = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_rd || mem_we) begin
            if (lat_cnt > 0) begin
                lat_cnt--;
            end else begin
                mem_ready = 1'b1;
                lat_cnt   = $urandom_range(0, 2);
                if (mem_rd) begin
                    mem_rdata = bmem[mem_addr];
                    check_eq("mem_rd_expected", {63'd0, mr_q.size() != 0}, 64'd1);
                    if (mr_q.size() != 0) check_eq("mem_rd_addr", 64'(mem_addr), 64'(mr_q.pop_front()));
                end else begin
                    bmem[mem_addr] = mem_wdata;
                    check_eq("mem_we_expected", {63'd0, mw_q.size() != 0}, 64'd1);
                    if (mw_q.size() != 0) check_eq("mem_we_addr_data", 64'({mem_addr, mem_wdata}), 64'(mw_q.pop_front()));
                end
            end
        end

        if (sd_buff_wr) begin
            check_eq("strobe_expected", {63'd0, rd_q.size() != 0}, 64'd1);
            if (rd_q.size() != 0) check_eq("strobe_addr_data", 64'({sd_buff_addr, sd_buff_dout}), 64'(rd_q.pop_front()));
            if (sd_buff_addr == 8'hFF) check_eq("ack_at_last_word", {63'd0, sd_ack}, 64'd1);
        end

        if (sd_ack && !ack_prev) ack_rises++;
        ack_prev = sd_ack;
    end

    task automatic push_read(input logic [31:0] lba);
        logic oor;
        oor = (lba >> LBA_BITS) != 32'd0;
        for (int k = 0; k < 256; k++) begin
            logic [13:0] a;
            a = {lba[LBA_BITS-1:0], 8'(k)};
            rd_q.push_back({8'(k), oor ? 16'h0000 : bmem[a]});
            if (!oor) mr_q.push_back(a);
        end
    endtask

    task automatic push_write(input logic [31:0] lba);
        if ((lba >> LBA_BITS) == 32'd0)
            for (int k = 0; k < 256; k++)
                mw_q.push_back({lba[LBA_BITS-1:0], 8'(k), ~16'(k)});
    endtask

    // Called at a negedge. b2b returns right at the sd_ack fall.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] lba, input logic b2b);
        int n, n_busy, n_ack;
        sd_lba = lba;
        sd_rd  = rd;
        sd_wr  = wr;
        n = 0; n_busy = -1; n_ack = -1;
        while (n_ack < 0 && n < 60) begin
            @(negedge clk_sys);
            n++;
            if (busy && n_busy < 0) n_busy = n;
            if (sd_ack) n_ack = n;
        end
        check_eq("ack_seen", {63'd0, n_ack > 0}, 64'd1);
        if (!b2b) begin
            check_eq("accept_latency", 64'(n_busy), 64'd1);
            check_eq("ack_delay", 64'(n_ack - n_busy), 64'(ACK_DELAY));
        end
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        n = 0;
        while (sd_ack && n < 6000) begin
            @(negedge clk_sys);
            n++;
        end
        check_eq("ack_fall", {63'd0, sd_ack}, 64'd0);
        if (!b2b) begin
            check_eq("done_busy", {63'd0, busy}, 64'd1);
            @(negedge clk_sys);
            check_eq("gap_busy", {63'd0, busy}, 64'd1);
            @(negedge clk_sys);
            check_eq("idle_busy", {63'd0, busy}, 64'd0);
        end
    endtask

    initial begin
        #1_500_000;
        n_fail++;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        sd_lba    = '0;
        sd_rd     = 1'b0;
        sd_wr     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        buf_pipe  = '0;
        sd_buff_din = '0;
        lat_cnt   = 0;
        ack_prev  = 1'b0;
        ack_rises = 0;
        for (int a = 0; a < 16384; a++) bmem[a] = 16'(a) ^ 16'h5A5A;
        for (int k = 0; k < 256; k++) begin
            bmem[14'h300 + 14'(k)] = 16'h1000 + 16'(k);
            core_buf[k] = ~16'(k);
        end

        repeat (3) @(negedge clk_sys);
        check_eq("reset_outputs",
                 64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                      mem_rd, mem_we, mem_wdata, busy, err}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        check_eq("idle_after_reset", {63'd0, busy}, 64'd0);

        // Read of lba 3: words 0x1000+k from 0x300+k.
        push_read(32'd3);
        run_req(1'b1, 1'b0, 32'd3, 1'b0);
        check_eq("read_lba3_drained", 64'(rd_q.size() + mr_q.size()), 64'd0);

        // Write of lba 5 from buffer words ~k.
        push_write(32'd5);
        run_req(1'b0, 1'b1, 32'd5, 1'b0);
        check_eq("write_lba5_drained", 64'(mw_q.size()), 64'd0);
        check_eq("write_lba5_word0", 64'(bmem[14'h500]), 64'hFFFF);
        check_eq("write_lba5_word255", 64'(bmem[14'h5FF]), 64'hFF00);
        check_eq("err_in_range", {63'd0, err}, 64'd0);

        // Both requests together: read wins, no writes expected.
        push_read(32'd0);
        run_req(1'b1, 1'b1, 32'd0, 1'b0);
        check_eq("priority_drained", 64'(rd_q.size() + mr_q.size() + mw_q.size()), 64'd0);

        // Out of range read and write.
        push_read(32'd64);
        run_req(1'b1, 1'b0, 32'd64, 1'b0);
        check_eq("oor_read_drained", 64'(rd_q.size()), 64'd0);
        check_eq("err_set", {63'd0, err}, 64'd1);
        push_write(32'h8000_0000);
        run_req(1'b0, 1'b1, 32'h8000_0000, 1'b0);
        check_eq("err_held_oor_write", {63'd0, err}, 64'd1);
        push_read(32'd7);
        run_req(1'b1, 1'b0, 32'd7, 1'b0);
        check_eq("err_held", {63'd0, err}, 64'd1);

        // Reset in the middle of a read at word 100.
        begin
            int n;
            push_read(32'd2);
            sd_lba = 32'd2;
            sd_rd  = 1'b1;
            n = 0;
            while (!(sd_buff_wr && sd_buff_addr == 8'd100) && n < 3000) begin
                @(negedge clk_sys);
                n++;
                if (sd_ack) sd_rd = 1'b0;
            end
            check_eq("reached_word100", {63'd0, sd_buff_wr && sd_buff_addr == 8'd100}, 64'd1);
            #2;
            reset_n = 1'b0;
            #1;
            check_eq("reset_mid_outputs",
                     64'({sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                          mem_rd, mem_we, mem_wdata, busy, err}), 64'd0);
            sd_rd = 1'b0;
            rd_q.delete();
            mr_q.delete();
            repeat (4) @(negedge clk_sys);
            check_eq("reset_hold_outputs", 64'({sd_ack, sd_buff_wr, mem_rd, mem_we, busy}), 64'd0);
            reset_n = 1'b1;
            @(negedge clk_sys);
            push_read(32'd1);
            run_req(1'b1, 1'b0, 32'd1, 1'b0);
            check_eq("after_reset_drained", 64'(rd_q.size() + mr_q.size()), 64'd0);
        end

        // Back-to-back reads of 16 consecutive sectors.
        begin
            int n;
            int rises0;
            rises0 = ack_rises;
            for (int s = 0; s < 16; s++) push_read(32'(8 + s));
            for (int s = 0; s < 16; s++) run_req(1'b1, 1'b0, 32'(8 + s), 1'b1);
            n = 0;
            while (busy && n < 20) begin
                @(negedge clk_sys);
                n++;
            end
            check_eq("b2b_idle", {63'd0, busy}, 64'd0);
            check_eq("b2b_transfers", 64'(ack_rises - rises0), 64'd16);
            check_eq("b2b_drained", 64'(rd_q.size() + mr_q.size()), 64'd0);
        end

        repeat (3) @(negedge clk_sys);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
